// File: rtl/instr_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instr_fetch_pkg;

    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_NOP    = 7'b0010011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface instr_fetch_if;
    // Request/ack handshake: the master raises imem_req with imem_addr and holds both
    // stable until the slave returns a one-cycle imem_ack pulse that qualifies imem_rdata.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_imm_gen.sv
// Combinational extraction of the sign-extended control-flow offset for the PC stage.
module imm_gen
    import instr_fetch_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [6:0]  OP,
    output logic [31:0] up_amt
);

    // The opcode field arrives separately on OP, already forced to NOP when not valid.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[6:0];

    always_comb begin
        up_amt = 32'h0;
        case (OP)
            OP_JAL:    up_amt = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_BRANCH: up_amt = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_JALR:   up_amt = {{21{instr[31]}}, instr[30:20]};
            default:   up_amt = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-entry instruction fetch stage: reads one word per request and holds it for decode.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          IP,
    input  logic                 dec_ready,
    input  logic                 flush,
    instr_fetch_if.master        imem,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic [6:0]           OP,
    output logic [31:0]          up_amt,
    output fetch_state_e         fsm_state
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_VALID = ST_VALID;
    localparam logic [1:0] S_DROP  = ST_DROP;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                addr_d  = IP;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // A flush without ack must still wait out the outstanding read in DROP.
                if (flush) begin
                    state_d = imem.imem_ack ? S_IDLE : S_DROP;
                end else if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (flush) begin
                    instr_d = NOP_INSTR;
                    state_d = S_IDLE;
                end else if (dec_ready) begin
                    addr_d  = IP;
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem.imem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    // Request is decoded from state so an asynchronous reset drops it at once.
    assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
    assign imem.imem_addr = addr_q;

    assign instr       = instr_q;
    assign instr_valid = (state_q == S_VALID);
    assign OP          = instr_valid ? instr_q[6:0] : OP_NOP;
    assign fsm_state   = fetch_state_e'(state_q);

    imm_gen u_imm_gen (
        .instr  (instr_q),
        .OP     (OP),
        .up_amt (up_amt)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, immediates, wait states, flush/drop and mid-fetch reset.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic         CLK;
    logic         RESET;
    logic [31:0]  IP;
    logic         dec_ready;
    logic         flush;
    logic [31:0]  instr;
    logic         instr_valid;
    logic [6:0]   OP;
    logic [31:0]  up_amt;
    fetch_state_e fsm_state;

    int checks   = 0;
    int failures = 0;

    instr_fetch_if imem_bus ();

    instr_fetch dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IP          (IP),
        .dec_ready   (dec_ready),
        .flush       (flush),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .OP          (OP),
        .up_amt      (up_amt),
        .fsm_state   (fsm_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; IP = 32'h0; dec_ready = 1'b0; flush = 1'b0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
        tick(); tick();
        checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
        checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 00000000", imem_bus.imem_addr); end
        checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (OP !== 7'b0010011) begin failures++; $display("FAIL reset_op: got %b expected 0010011", OP); end
        checks++; if (up_amt !== 32'h0) begin failures++; $display("FAIL reset_up_amt: got %h expected 00000000", up_amt); end
    endtask

    task automatic test_zero_wait();
        IP = 32'h0; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0000_0013;
        RESET = 1'b1;
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL zw_req: got %b expected 1", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("FAIL zw_addr: got %h expected 00000000", imem_bus.imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL zw_valid_early: got %b expected 0", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL zw_valid: got %b expected 1", instr_valid); end
        checks++; if (OP !== 7'b0010011) begin failures++; $display("FAIL zw_op: got %b expected 0010011", OP); end
        checks++; if (up_amt !== 32'h0) begin failures++; $display("FAIL zw_up_amt: got %h expected 00000000", up_amt); end
        imem_bus.imem_ack = 1'b0;
    endtask

    // dec_ready stays high across the table: one instruction every two cycles.
    task automatic test_imm();
        logic [31:0] words [6] = '{32'h0080_006F, 32'hFE00_0EE3, 32'hFFC0_8067,
                                    32'h0050_0093, 32'h1234_50B7, 32'h0020_9463};
        logic [6:0]  ops   [6] = '{7'b1101111, 7'b1100011, 7'b1100111,
                                    7'b0010011, 7'b0110111, 7'b1100011};
        logic [31:0] imms  [6] = '{32'h0000_0008, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                    32'h0000_0000, 32'h0000_0000, 32'h0000_0008};
        dec_ready = 1'b1; imem_bus.imem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            IP = 32'h1000 + 32'(i * 4);
            imem_bus.imem_rdata = words[i];
            tick();
            checks++; if (imem_bus.imem_addr !== IP) begin failures++; $display("FAIL imm_addr[%0d]: got %h expected %h", i, imem_bus.imem_addr, IP); end
            tick();
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL imm_valid[%0d]: got %b expected 1", i, instr_valid); end
            checks++; if (instr !== words[i]) begin failures++; $display("FAIL imm_instr[%0d]: got %h expected %h", i, instr, words[i]); end
            checks++; if (OP !== ops[i]) begin failures++; $display("FAIL imm_op[%0d]: got %b expected %b", i, OP, ops[i]); end
            checks++; if (up_amt !== imms[i]) begin failures++; $display("FAIL imm_up_amt[%0d]: got %h expected %h", i, up_amt, imms[i]); end
        end
        dec_ready = 1'b0; imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_ack_delay();
        IP = 32'h0000_0100; dec_ready = 1'b1; imem_bus.imem_ack = 1'b0;
        tick();
        dec_ready = 1'b0; IP = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL delay_req[%0d]: got %b expected 1", i, imem_bus.imem_req); end
            checks++; if (imem_bus.imem_addr !== 32'h0000_0100) begin failures++; $display("FAIL delay_addr[%0d]: got %h expected 00000100", i, imem_bus.imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL delay_valid[%0d]: got %b expected 0", i, instr_valid); end
            tick();
        end
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0080_006F;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL delay_valid_after_ack: got %b expected 1", instr_valid); end
        checks++; if (instr !== 32'h0080_006F) begin failures++; $display("FAIL delay_instr: got %h expected 0080006f", instr); end
    endtask

    task automatic test_flush_fetch();
        IP = 32'h0000_0200; dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 1) flush = 1'b0;
            checks++; if (fsm_state !== ST_DROP) begin failures++; $display("FAIL drop_state[%0d]: got %0d expected %0d", i, fsm_state, ST_DROP); end
            checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0200) begin failures++; $display("FAIL drop_req[%0d]: got %b/%h expected 1/00000200", i, imem_bus.imem_req, imem_bus.imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL drop_valid[%0d]: got %b expected 0", i, instr_valid); end
        end
        flush = 1'b0; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hFE00_0EE3;
        tick();
        imem_bus.imem_ack = 1'b0; IP = 32'h0000_0300;
        checks++; if (fsm_state !== ST_IDLE || instr_valid !== 1'b0) begin failures++; $display("FAIL drop_discard: got state %0d valid %b expected 0/0", fsm_state, instr_valid); end
        checks++; if (imem_bus.imem_req !== 1'b0 || OP !== 7'b0010011) begin failures++; $display("FAIL drop_idle_out: got %b/%b expected 0/0010011", imem_bus.imem_req, OP); end
        tick();
        checks++; if (imem_bus.imem_addr !== 32'h0000_0300 || instr_valid !== 1'b0) begin failures++; $display("FAIL drop_refetch: got %h/%b expected 00000300/0", imem_bus.imem_addr, instr_valid); end
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0050_0093;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093) begin failures++; $display("FAIL drop_next_word: got %b/%h expected 1/00500093", instr_valid, instr); end
    endtask

    task automatic test_flush_ack();
        IP = 32'h0000_0600; dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0; flush = 1'b1; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0080_006F;
        tick();
        flush = 1'b0; imem_bus.imem_ack = 1'b0;
        checks++; if (fsm_state !== ST_IDLE || instr_valid !== 1'b0) begin failures++; $display("FAIL flush_ack: got state %0d valid %b expected 0/0", fsm_state, instr_valid); end
        tick();
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hFE00_0EE3;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hFE00_0EE3) begin failures++; $display("FAIL flush_ack_next: got %b/%h expected 1/fe000ee3", instr_valid, instr); end
    endtask

    task automatic test_hold_then_flush();
        dec_ready = 1'b0;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr !== 32'hFE00_0EE3) begin failures++; $display("FAIL hold_instr[%0d]: got %b/%h expected 1/fe000ee3", i, instr_valid, instr); end
            checks++; if (OP !== 7'b1100011 || up_amt !== 32'hFFFF_FFFC) begin failures++; $display("FAIL hold_op[%0d]: got %b/%h expected 1100011/fffffffc", i, OP, up_amt); end
        end
        imem_bus.imem_ack = 1'b0; flush = 1'b1; dec_ready = 1'b1;
        tick();
        flush = 1'b0; dec_ready = 1'b0;
        checks++; if (fsm_state !== ST_IDLE || instr_valid !== 1'b0) begin failures++; $display("FAIL hold_flush_state: got %0d/%b expected 0/0", fsm_state, instr_valid); end
        checks++; if (OP !== 7'b0010011 || up_amt !== 32'h0) begin failures++; $display("FAIL hold_flush_op: got %b/%h expected 0010011/00000000", OP, up_amt); end
    endtask

    task automatic test_reset_mid_fetch();
        IP = 32'h0000_0400; imem_bus.imem_ack = 1'b0;
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0400) begin failures++; $display("FAIL rst_pre_req: got %b/%h expected 1/00000400", imem_bus.imem_req, imem_bus.imem_addr); end
        RESET = 1'b0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0 || fsm_state !== ST_IDLE) begin failures++; $display("FAIL rst_drop_req: got %b/%0d expected 0/0", imem_bus.imem_req, fsm_state); end
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0080_006F; IP = 32'h0000_0500;
        tick();
        RESET = 1'b1;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (fsm_state !== ST_FETCH || instr_valid !== 1'b0) begin failures++; $display("FAIL rst_late_ack: got %0d/%b expected 1/0", fsm_state, instr_valid); end
        checks++; if (imem_bus.imem_addr !== 32'h0000_0500) begin failures++; $display("FAIL rst_addr: got %h expected 00000500", imem_bus.imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_wait: got %b expected 0", instr_valid); end
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0050_0093;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || up_amt !== 32'h0) begin failures++; $display("FAIL rst_refetch: got %b/%h/%h expected 1/00500093/00000000", instr_valid, instr, up_amt); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_imm();
        test_ack_delay();
        test_flush_fetch();
        test_flush_ack();
        test_hold_then_flush();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL expose the following ports, clock and reset first, as: name direction width meaning.
REQ-002 CLK input 1: the single clock; all state SHALL update on its rising edge.
REQ-003 RESET input 1: reset, asynchronous, active-low.
REQ-004 IP input 32: current instruction pointer from the PC stage.
REQ-005 dec_ready input 1: the downstream decode stage accepts the held instruction this cycle.
REQ-006 flush input 1: a taken branch or jump has redirected the PC; any held or in-flight instruction is discarded.
REQ-007 imem_req output 1: instruction-memory read request.
REQ-008 imem_addr output 32: instruction-memory read address.
REQ-009 imem_ack input 1: single-cycle pulse that qualifies imem_rdata.
REQ-010 imem_rdata input 32: instruction word returned by memory.
REQ-011 instr output 32: held instruction word.
REQ-012 instr_valid output 1: instr, OP and up_amt are valid.
REQ-013 OP output 7: opcode of the held instruction, driven to the PC stage.
REQ-014 up_amt output 32: sign-extended control-flow offset, driven to the PC stage.

Function
REQ-015 The block SHALL have four states: IDLE, FETCH, VALID and DROP.
REQ-016 In IDLE, the block SHALL latch IP into addr_q and go to FETCH on the next edge.
REQ-017 In FETCH, the block SHALL drive imem_req=1 and imem_addr=addr_q, holding both stable until imem_ack.
REQ-018 In FETCH with imem_ack=1 and flush=0, the block SHALL capture imem_rdata into instr_q and go to VALID.
REQ-019 In FETCH with flush=1 and imem_ack=1, the block SHALL discard the data and go to IDLE.
REQ-020 In FETCH with flush=1 and imem_ack=0, the block SHALL go to DROP.
REQ-021 In DROP, imem_req SHALL remain 1 with the same address; on imem_ack the data SHALL be discarded and the block SHALL go to IDLE; a further flush in DROP SHALL have no effect.
REQ-022 In VALID, instr_valid SHALL be 1.
- flush=1: go to IDLE and discard the instruction; flush takes priority over dec_ready.
- dec_ready=1 and flush=0: latch IP into addr_q and go directly to FETCH.
- Otherwise: hold.
REQ-023 imem_ack SHALL be ignored in IDLE and VALID.
REQ-024 instr_valid SHALL be 1 only in VALID; instr, OP and up_amt SHALL be stable while instr_valid is held.
REQ-025 When instr_valid=0, OP SHALL be 7'b0010011 (NOP opcode) so that the PC stage never stalls on a stale opcode.
REQ-026 OP SHALL be instr_q[6:0] when instr_valid=1.
REQ-027 up_amt SHALL be selected by OP:
- 1101111 (JAL): J-immediate.
- 1100011 (branch): B-immediate.
- 1100111 (JALR): I-immediate.
- Any other opcode: 0.
- All immediates SHALL be sign-extended to 32 bits from instr_q[31].
REQ-028 Minimum latency SHALL be 2 cycles from the IP latch to instr_valid=1, with a zero-wait memory (ack in the first FETCH cycle).
REQ-029 Sustained throughput SHALL be one instruction per 2 cycles with zero-wait memory and dec_ready held at 1.

Reset
REQ-030 While RESET=0, the block SHALL be in IDLE with:
- addr_q = 0
- instr_q = 32'h00000013
- imem_req = 0
- instr_valid = 0
- OP = 7'b0010011
- up_amt = 0
REQ-031 A reset asserted mid-request SHALL drop the request immediately; any imem_ack arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold:
- the opcode constants for JAL, JALR, BRANCH and NOP;
- the NOP instruction word 32'h00000013;
- the fetch state enum.
REQ-033 Immediate extraction SHALL be a combinational sub-module named imm_gen (inputs: instr, OP; output: up_amt).

Verification
REQ-034 Reset, then IP=0x00000000, with memory acking in the first FETCH cycle and rdata=0x00000013 -> imem_addr=0x0, and instr_valid=1 two cycles after reset release with OP=0010011 and up_amt=0.
REQ-035 rdata=0x0080006F (JAL +8) -> OP=1101111 and up_amt=0x00000008; rdata=0xFE000EE3 (BEQ -4) -> OP=1100011 and up_amt=0xFFFFFFFC.
REQ-036 Ack delayed 5 cycles -> imem_req=1 and imem_addr stable for all 5 cycles, and instr_valid rises on the cycle after ack.
REQ-037 flush in FETCH, ack 3 cycles later -> DROP is entered, imem_req is held until ack, the data is discarded, and instr_valid never rises for that word.
REQ-038 VALID with dec_ready=0 for 4 cycles, then flush and dec_ready together -> instr is held stable, then the block goes to IDLE with instr_valid=0 the next cycle and OP=0010011.
REQ-039 RESET pulled low during FETCH -> imem_req=0 immediately, and a late ack after release is ignored.
